// File: rtl/sd_cmd_response_receiver.sv
// rtl/sd_cmd_response_receiver.sv - SD CMD-line response deserialiser with CRC7, frame and Ncr timeout checks
module sd_cmd_response_receiver #(
  parameter int TIMEOUT_BITS = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sample_en,
  input  logic         cmd_pin_in,
  input  logic         start,
  input  logic         resp_long,
  input  logic         check_crc,
  output logic         busy,
  output logic         done,
  output logic [127:0] response_out,
  output logic [5:0]   resp_index,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout_err
);

  localparam int TW = $clog2(TIMEOUT_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    DONE_ST
  } state_t;

  state_t          state, state_nx;
  logic            long_q, chk_q;
  logic [7:0]      bit_cnt, bit_nx;
  logic [TW-1:0]   to_cnt;
  logic [6:0]      crc_q, crc_shift;
  logic [132:0]    shift_q;
  logic            last_bit, crc_feed, to_hit, fb;

  assign busy      = (state != IDLE);
  assign bit_nx    = bit_cnt + 8'd1;
  assign last_bit  = (bit_nx == (long_q ? 8'd136 : 8'd48));
  // R2 CRC covers only the CID/CSD body, not the start/transmission/index header
  assign crc_feed  = long_q ? (bit_nx >= 8'd9 && bit_nx <= 8'd128) : (bit_nx <= 8'd40);
  assign fb        = crc_q[6] ^ cmd_pin_in;
  assign crc_shift = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  assign to_hit    = ((to_cnt + TW'(1)) == TW'(TIMEOUT_BITS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (start) state_nx = WAIT_START;
      WAIT_START: if (sample_en) begin
                    if (!cmd_pin_in)  state_nx = RECEIVE;
                    else if (to_hit)  state_nx = DONE_ST;
                  end
      RECEIVE:    if (sample_en && last_bit) state_nx = DONE_ST;
      DONE_ST:    state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done         <= 1'b0;
      response_out <= '0;
      resp_index   <= '0;
      crc_err      <= 1'b0;
      frame_err    <= 1'b0;
      timeout_err  <= 1'b0;
      long_q       <= 1'b0;
      chk_q        <= 1'b0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      crc_q        <= '0;
      shift_q      <= '0;
    end else begin
      done <= (state == DONE_ST);
      case (state)
        IDLE: if (start) begin
          long_q      <= resp_long;
          chk_q       <= check_crc;
          crc_err     <= 1'b0;
          frame_err   <= 1'b0;
          timeout_err <= 1'b0;
          to_cnt      <= '0;
          bit_cnt     <= '0;
          crc_q       <= '0;
        end
        WAIT_START: if (sample_en) begin
          if (!cmd_pin_in) begin
            bit_cnt <= 8'd1;
            crc_q   <= crc_shift;
            shift_q <= {shift_q[131:0], 1'b0};
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (to_hit) timeout_err <= 1'b1;
          end
        end
        RECEIVE: if (sample_en) begin
          shift_q <= {shift_q[131:0], cmd_pin_in};
          bit_cnt <= bit_nx;
          if (bit_nx == 8'd2 && cmd_pin_in) frame_err <= 1'b1;
          if (crc_feed) crc_q <= crc_shift;
          // shift_q holds frame bits 1..N-1 with the latest in bit 0; received CRC is shift_q[6:0]
          if (last_bit) begin
            frame_err <= frame_err | ~cmd_pin_in;
            crc_err   <= chk_q & (crc_q != shift_q[6:0]);
            if (long_q) begin
              resp_index   <= shift_q[132:127];
              response_out <= {shift_q[126:0], 1'b0};
            end else begin
              resp_index   <= shift_q[44:39];
              response_out <= {96'b0, shift_q[38:7]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_response_receiver.sv
// tb/tb_sd_cmd_response_receiver.sv - scoreboard bench for sd_cmd_response_receiver
module tb_sd_cmd_response_receiver;

  localparam int TIMEOUT_BITS = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         sample_en = 1'b0;
  logic         cmd_pin_in = 1'b1;
  logic         start = 1'b0;
  logic         resp_long = 1'b0;
  logic         check_crc = 1'b0;
  logic         busy, done, crc_err, frame_err, timeout_err;
  logic [127:0] response_out;
  logic [5:0]   resp_index;

  sd_cmd_response_receiver #(.TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .cmd_pin_in(cmd_pin_in),
    .start(start), .resp_long(resp_long), .check_crc(check_crc),
    .busy(busy), .done(done), .response_out(response_out), .resp_index(resp_index),
    .crc_err(crc_err), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]   idx;
    logic [127:0] resp;
    logic         crc_e;
    logic         frame_e;
    logic         to_e;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           tests = 0;
  int           fails = 0;
  logic [127:0] mdl_resp = '0;
  logic [5:0]   mdl_idx = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // CRC7 as polynomial long division: remainder of M(x)*x^7 mod (x^7+x^3+1)
  function automatic logic [6:0] crc7_ref(input logic [119:0] m, input int n);
    logic [127:0] rem;
    rem = {8'b0, m} << 7;
    for (int i = n + 6; i >= 7; i--)
      if (rem[i]) rem = rem ^ (128'h89 << (i - 7));
    return rem[6:0];
  endfunction

  always @(negedge clock) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending response");
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_index", 128'(resp_index), 128'(mon_e.idx));
        check("response_out", response_out, mon_e.resp);
        check("crc_err", 128'(crc_err), 128'(mon_e.crc_e));
        check("frame_err", 128'(frame_err), 128'(mon_e.frame_e));
        check("timeout_err", 128'(timeout_err), 128'(mon_e.to_e));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic b, input bit allow_junk);
    int g;
    g = int'($urandom_range(0, 2));
    repeat (g) begin
      start = allow_junk && ($urandom_range(0, 7) == 0);
      tick();
      start = 1'b0;
    end
    cmd_pin_in = b;
    sample_en  = 1'b1;
    tick();
    sample_en  = 1'b0;
    cmd_pin_in = 1'b1;
  endtask

  task automatic do_start(input logic lng, input logic chk);
    start     = 1'b1;
    resp_long = lng;
    check_crc = chk;
    if ($urandom_range(0, 1) == 1) begin
      sample_en  = 1'b1;
      cmd_pin_in = 1'b0;
    end
    tick();
    start      = 1'b0;
    sample_en  = 1'b0;
    cmd_pin_in = 1'b1;
    resp_long  = 1'($urandom);
    check_crc  = 1'($urandom);
    check("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic wait_done();
    @(negedge clock);
    check("done_early", 128'(done), 128'(0));
    @(negedge clock);
    check("done_latency", 128'(done), 128'(1));
    check("busy_at_done", 128'(busy), 128'(0));
    @(posedge clock);
    #1;
    check("done_one_clock", 128'(done), 128'(0));
  endtask

  task automatic send_short(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                            input logic t, input logic e, input logic chk, input int lead);
    logic [47:0] f;
    exp_t        x;
    f         = {1'b0, t, idx, arg, crc, e};
    x.idx     = idx;
    x.resp    = {96'b0, arg};
    x.crc_e   = chk && (crc != crc7_ref({80'b0, f[47:8]}, 40));
    x.frame_e = t | ~e;
    x.to_e    = 1'b0;
    mdl_idx   = idx;
    mdl_resp  = x.resp;
    exp_q.push_back(x);
    do_start(1'b0, chk);
    repeat (lead) strobe(1'b1, 1'b0);
    for (int i = 47; i >= 0; i--) strobe(f[i], 1'b1);
    wait_done();
  endtask

  task automatic send_long(input logic [5:0] idx, input logic [119:0] pl, input logic [6:0] crc,
                           input logic t, input logic e, input logic chk, input int lead);
    logic [135:0] f;
    exp_t         x;
    f         = {1'b0, t, idx, pl, crc, e};
    x.idx     = idx;
    x.resp    = {pl, crc, 1'b0};
    x.crc_e   = chk && (crc != crc7_ref(pl, 120));
    x.frame_e = t | ~e;
    x.to_e    = 1'b0;
    mdl_idx   = idx;
    mdl_resp  = x.resp;
    exp_q.push_back(x);
    do_start(1'b1, chk);
    repeat (lead) strobe(1'b1, 1'b0);
    for (int i = 135; i >= 0; i--) strobe(f[i], 1'b1);
    wait_done();
  endtask

  task automatic send_timeout();
    exp_t x;
    x.idx     = mdl_idx;
    x.resp    = mdl_resp;
    x.crc_e   = 1'b0;
    x.frame_e = 1'b0;
    x.to_e    = 1'b1;
    exp_q.push_back(x);
    do_start(1'($urandom), 1'b1);
    repeat (TIMEOUT_BITS) strobe(1'b1, 1'b1);
    wait_done();
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] pl;
    logic [31:0]  arg;
    logic [6:0]   crc;
    logic [5:0]   idx;
    logic [47:0]  f;

    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_resp", response_out, 128'(0));
    check("rst_idx", 128'(resp_index), 128'(0));
    check("rst_errs", 128'({crc_err, frame_err, timeout_err}), 128'(0));
    repeat (2) tick();
    reset = 1'b1;
    tick();

    send_short(6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b1, 1'b1, 3);
    check("r1_idx_held", 128'(resp_index), 128'(6'h11));
    check("r1_resp_held", response_out, 128'h900);
    send_short(6'h11, 32'h0000_0900, 7'h32, 1'b0, 1'b1, 1'b1, 2);
    send_short(6'h11, 32'h0000_0900, 7'h32, 1'b0, 1'b1, 1'b0, 2);
    send_short(6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b0, 1'b1, 1);
    send_short(6'h0D, 32'h1234_5678, crc7_ref({80'b0, 2'b01, 6'h0D, 32'h1234_5678}, 40),
               1'b1, 1'b1, 1'b1, 0);
    send_timeout();
    send_short(6'h08, 32'h0000_01AA, crc7_ref({80'b0, 2'b00, 6'h08, 32'h0000_01AA}, 40),
               1'b0, 1'b1, 1'b1, TIMEOUT_BITS - 1);

    pl = {15{8'hA5}};
    send_long(6'h3F, pl, crc7_ref(pl, 120), 1'b0, 1'b1, 1'b1, 4);

    do_start(1'b0, 1'b1);
    f = {2'b00, 6'h2A, 32'hDEAD_BEEF, 7'h11, 1'b1};
    for (int i = 47; i >= 28; i--) strobe(f[i], 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    check("midrst_resp", response_out, 128'(0));
    check("midrst_idx", 128'(resp_index), 128'(0));
    check("midrst_errs", 128'({crc_err, frame_err, timeout_err}), 128'(0));
    mdl_resp = '0;
    mdl_idx  = '0;
    tick();
    reset = 1'b1;
    tick();
    send_short(6'h03, 32'hAAAA_0520, crc7_ref({80'b0, 2'b00, 6'h03, 32'hAAAA_0520}, 40),
               1'b0, 1'b1, 1'b1, 5);

    for (int n = 0; n < 30; n++) begin
      idx = 6'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        pl  = {$urandom, $urandom, $urandom, 24'($urandom)};
        crc = ($urandom_range(0, 3) != 0) ? crc7_ref(pl, 120) : 7'($urandom);
        send_long(idx, pl, crc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 4) != 0), int'($urandom_range(0, 10)));
      end else begin
        arg = $urandom;
        crc = 7'($urandom);
        if ($urandom_range(0, 3) != 0) crc = crc7_ref({80'b0, 2'b00, idx, arg}, 40);
        send_short(idx, arg, crc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 4) != 0), int'($urandom_range(0, 10)));
      end
      if ($urandom_range(0, 9) == 0) send_timeout();
    end

    repeat (4) tick();
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_cmd_response_receiver.md
Name: sd_cmd_response_receiver

Overview:
- Command-line response receiver of the SDHOST command path.
- Sits directly downstream of the cmd pin (cmd_pin_in). Deserialises R1/R1b/R3/R6/R7 (48-bit) and R2 (136-bit) responses, checks CRC7, start/transmission/end bits and the Ncr timeout.
- Delivers the 128-bit response payload and status to the register block, which fills response_outReg.

Parameters:
- TIMEOUT_BITS, 64, number of sample_en strobes waited for a start bit before timeout_err.

Ports:
- clock  input  1  system clock; all logic rises on posedge.
- reset  input  1  asynchronous, active-low reset.
- sample_en  input  1  one-clock strobe per SD bit time; cmd_pin_in is sampled only when high.
- cmd_pin_in  input  1  SD CMD line, already synchronised.
- start  input  1  one-clock pulse from the command sender after the end bit of the command is sent.
- resp_long  input  1  latched at start: 1 = 136-bit R2, 0 = 48-bit.
- check_crc  input  1  latched at start: 0 disables CRC check (R3).
- busy  output  1  high from the clock after an accepted start until done.
- done  output  1  one-clock pulse at the end of a reception or timeout.
- response_out  output  128  response payload.
- resp_index  output  6  received command-index field.
- crc_err  output  1  CRC7 mismatch, held.
- frame_err  output  1  transmission bit != 0 or end bit != 1, held.
- timeout_err  output  1  no start bit within TIMEOUT_BITS, held.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, response_out=0, resp_index=0, all errors=0, bit counter=0, CRC register=0.
- States:
  - IDLE: start=1 -> WAIT_START. On the same edge, latch resp_long/check_crc, clear all errors and the timeout counter. start while not IDLE is ignored.
  - WAIT_START: on each sample_en:
    - cmd_pin_in=0 -> RECEIVE, bit counter=1, CRC fed with 0.
    - else the timeout counter increments. When it reaches TIMEOUT_BITS -> DONE with timeout_err=1. response_out and resp_index are unchanged.
  - RECEIVE: on each sample_en, shift cmd_pin_in into the shift register and increment the bit counter. The total frame is 48 or 136 bits including the start bit.
    - Bit 2 (transmission bit) = 1 sets the frame_err flag.
    - CRC-covered bits feed the CRC7 (x^7+x^3+1, init 0):
      - short: bits 1-40 (start, transmission, index, argument).
      - long: bits 9-128 only, i.e. the 120 CID/CSD bits [127:8].
    - Received CRC: bits 41-47 (short) or 129-135 (long).
    - On the final bit (48/136): frame_err |= (bit != 1); crc_err = check_crc & (computed != received) -> DONE.
  - DONE: done=1 for exactly one clock; outputs updated on the same edge -> IDLE.
- Output mapping, updated only on the transition into DONE from RECEIVE:
  - short: resp_index = bits 3-8; response_out = {96'b0, argument[31:0]}.
  - long: resp_index = bits 3-8 (expected 6'h3F, not checked); response_out[127:1] = bits 9-135 (CID/CSD[127:1] including CRC); response_out[0] = 0.
- busy = (state != IDLE); it drops on the same edge that done rises.
- Latency: done rises on the clock edge after the sample_en that captured the end bit.
- Boundary cases:
  - start coincident with sample_en: that strobe is not sampled.
  - sample_en low: state, counters and CRC are frozen.
  - Timeout is reached exactly on the strobe equal to TIMEOUT_BITS; a start bit on that same strobe wins.
  - Reset asserted mid-frame: immediate return to IDLE and all outputs cleared.

Test Plan:
- Short R1 frame 0x11_00000900_33 + end bit 1, check_crc=1 -> done after 48th strobe; resp_index=6'h11, response_out=128'h900, crc_err=0, frame_err=0.
- Same frame with CRC byte 0x32 -> crc_err=1; repeat with check_crc=0 -> crc_err=0.
- Short frame with end bit 0, then a separate frame with transmission bit 1 -> frame_err=1 in each case, done still pulses once.
- Line held high after start, TIMEOUT_BITS=64 -> done and timeout_err=1 on the 64th strobe; start bit on the 64th strobe -> no timeout, reception proceeds.
- R2 with header 0x3F and 120-bit payload A5A5…A5 plus correct CRC7 -> response_out[127:8]=payload, [7:1]=CRC, [0]=0, resp_index=6'h3F, no errors.
- Reset pulled low at bit 20 of a frame -> busy=0 immediately, outputs zero. A following start with a clean frame is received correctly; start pulses during busy are ignored.
